// File: rtl/multi_bit_sync_filter.sv
// Purpose : per-channel N-flop synchronizer followed by a stability (glitch) filter and optional edge pulses.
// Latency : level first sampled at edge k shows on o_data after edge k+NB_STAGES+FILTER_CYCLES-1.
// Backpres: none; i_enable=0 freezes filter counters and o_data while the sync chains keep shifting.
//
// Ports:
//   i_clock   - destination clock, all state updates on its rising edge
//   i_reset_n - synchronous active-low reset
//   i_data    - NB_CH asynchronous level inputs
//   i_enable  - filter/output update enable
//   o_data    - synchronized and filtered levels
//   o_rise    - one-cycle pulse per channel when o_data goes 0->1
//   o_fall    - one-cycle pulse per channel when o_data goes 1->0
//   o_changed - high in any cycle where some o_rise/o_fall bit is high
//
// Macro MULTI_BIT_SYNC_EDGE_DETECT_EN: when defined the edge pulse registers are built;
// when undefined o_rise/o_fall/o_changed are constant 0 and o_data is unaffected.
// Not for buses whose bits must stay coherent: each channel settles independently.

module multi_bit_sync_filter #(
   parameter int               NB_CH         = 4,
   parameter int               NB_STAGES     = 2,
   parameter int               FILTER_CYCLES = 3,
   parameter logic [NB_CH-1:0] RESET_VALUE   = '0
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic [NB_CH-1:0] i_data,
   input  logic             i_enable,
   output logic [NB_CH-1:0] o_data,
   output logic [NB_CH-1:0] o_rise,
   output logic [NB_CH-1:0] o_fall,
   output logic             o_changed
);

   // A 1-cycle filter still needs a 1-bit counter field to keep the vector legal.
   localparam int              CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   if (NB_STAGES < 2) begin : g_bad_stages
      $error("multi_bit_sync_filter: NB_STAGES must be >= 2");
   end
   if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("multi_bit_sync_filter: FILTER_CYCLES must be >= 1");
   end

   // Synchronizer chains: index 0 is the metastability-capturing stage.
   logic [NB_STAGES-1:0][NB_CH-1:0] sync_q;
   logic [NB_CH-1:0]                sync_s;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         sync_q <= {NB_STAGES{RESET_VALUE}};
      end else begin
         sync_q <= {sync_q[NB_STAGES-2:0], i_data};
      end
   end

   assign sync_s = sync_q[NB_STAGES-1];

   // Stability filter: o_data only follows sync_s after FILTER_CYCLES consecutive
   // enabled cycles of disagreement. The counter saturates at CNT_LAST and is
   // cleared on update, so it can never wrap.
   logic [NB_CH-1:0][CNT_W-1:0] cnt_q;
   logic [NB_CH-1:0][CNT_W-1:0] cnt_d;
   logic [NB_CH-1:0]            upd;
   logic [NB_CH-1:0]            data_d;

   always_comb begin
      cnt_d = cnt_q;
      upd   = '0;
      for (int ch = 0; ch < NB_CH; ch++) begin
         if (i_enable) begin
            if (sync_s[ch] == o_data[ch]) begin
               cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
               upd[ch]   = 1'b1;
               cnt_d[ch] = '0;
            end else begin
               cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
         end
      end
      data_d = (o_data & ~upd) | (sync_s & upd);
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         o_data <= RESET_VALUE;
         cnt_q  <= '0;
      end else begin
         o_data <= data_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef MULTI_BIT_SYNC_EDGE_DETECT_EN
   // Pulses are registered alongside o_data so they line up with the new value.
   // upd is zero while disabled, which also clears the pulses.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         o_rise    <= '0;
         o_fall    <= '0;
         o_changed <= 1'b0;
      end else begin
         o_rise    <= upd & sync_s;
         o_fall    <= upd & ~sync_s;
         o_changed <= |upd;
      end
   end
`else
   assign o_rise    = '0;
   assign o_fall    = '0;
   assign o_changed = 1'b0;
`endif

endmodule

// File: tb/tb_multi_bit_sync_filter.sv
// Directed, table-driven bench for multi_bit_sync_filter at default parameters
// (4 channels, 2 sync stages, 3-cycle filter, reset value 0). Expected pulse
// values collapse to 0 when MULTI_BIT_SYNC_EDGE_DETECT_EN is undefined.

module tb_multi_bit_sync_filter;

   logic       i_clock = 1'b0;
   logic       i_reset_n;
   logic [3:0] i_data;
   logic       i_enable;
   logic [3:0] o_data;
   logic [3:0] o_rise;
   logic [3:0] o_fall;
   logic       o_changed;

   int n_chk  = 0;
   int n_fail = 0;

   multi_bit_sync_filter dut (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_data    (i_data),
      .i_enable  (i_enable),
      .o_data    (o_data),
      .o_rise    (o_rise),
      .o_fall    (o_fall),
      .o_changed (o_changed)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic [3:0] d;
      logic [3:0] exp_d;
      logic [3:0] exp_r;
      logic [3:0] exp_f;
      logic       exp_c;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [3:0] ep(input logic [3:0] v);
`ifdef MULTI_BIT_SYNC_EDGE_DETECT_EN
      return v;
`else
      return 4'h0 & v;
`endif
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive inputs, take one rising edge, then sample 1 time unit later.
   task automatic cycle(input logic r, input logic e, input logic [3:0] d,
                        input logic [3:0] ed, input logic [3:0] er,
                        input logic [3:0] ef, input logic ec, input string tag);
      i_reset_n = r;
      i_enable  = e;
      i_data    = d;
      @(posedge i_clock);
      #1;
      check({tag, ".o_data"},    o_data,            ed);
      check({tag, ".o_rise"},    o_rise,            ep(er));
      check({tag, ".o_fall"},    o_fall,            ep(ef));
      check({tag, ".o_changed"}, {3'b000, o_changed}, ep({3'b000, ec}));
   endtask

   task automatic add(input logic r, input logic e, input logic [3:0] d,
                      input logic [3:0] ed, input logic [3:0] er,
                      input logic [3:0] ef, input logic ec);
      vec_t v;
      v.rst_n = r; v.en = e; v.d = d;
      v.exp_d = ed; v.exp_r = er; v.exp_f = ef; v.exp_c = ec;
      vecs.push_back(v);
   endtask

   // A level held from the first edge: 4 edges with the old value, update on the 5th, quiet on the 6th.
   task automatic add_step(input logic [3:0] d, input logic [3:0] old_o, input logic [3:0] new_o,
                           input logic [3:0] r, input logic [3:0] f);
      for (int i = 0; i < 4; i++) add(1'b1, 1'b1, d, old_o, 4'h0, 4'h0, 1'b0);
      add(1'b1, 1'b1, d, new_o, r, f, 1'b1);
      add(1'b1, 1'b1, d, new_o, 4'h0, 4'h0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ed, er, ef;
      logic       ec;

      i_reset_n = 1'b0;
      i_enable  = 1'b1;
      i_data    = 4'hF;

      // Reset held 3 cycles with all inputs high: outputs stay at reset value.
      for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
      add_step(4'hF, 4'h0, 4'hF, 4'hF, 4'h0);   // release: all channels rise together
      add_step(4'h0, 4'hF, 4'h0, 4'h0, 4'hF);   // all channels fall together
      add_step(4'h1, 4'h0, 4'h1, 4'h1, 4'h0);   // clean ch0 step
      add_step(4'h9, 4'h1, 4'h9, 4'h8, 4'h0);   // ch3 up in preparation
      add_step(4'h5, 4'h9, 4'h5, 4'h4, 4'h8);   // ch2 rises and ch3 falls on the same edge

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].rst_n, vecs[i].en, vecs[i].d, vecs[i].exp_d,
               vecs[i].exp_r, vecs[i].exp_f, vecs[i].exp_c, $sformatf("vec%0d", i));
      end

      // Glitch of 2 cycles on ch1 never reaches o_data.
      for (int j = 0; j < 8; j++) begin
         cycle(1'b1, 1'b1, (j < 2) ? 4'h7 : 4'h5, 4'h5, 4'h0, 4'h0, 1'b0,
               $sformatf("glitch2_%0d", j));
      end

      // 3-cycle pulse on ch1 passes: rise after edge 4, fall 3 edges later.
      for (int j = 0; j < 9; j++) begin
         ed = (j >= 4 && j <= 6) ? 4'h7 : 4'h5;
         er = (j == 4) ? 4'h2 : 4'h0;
         ef = (j == 7) ? 4'h2 : 4'h0;
         ec = (j == 4 || j == 7);
         cycle(1'b1, 1'b1, (j < 3) ? 4'h7 : 4'h5, ed, er, ef, ec, $sformatf("glitch3_%0d", j));
      end

      // Enable gating: ch0 goes low; after 4 edges the counter holds 2 (one short of update).
      for (int j = 0; j < 4; j++)
         cycle(1'b1, 1'b1, 4'h4, 4'h5, 4'h0, 4'h0, 1'b0, $sformatf("en_run_%0d", j));
      for (int j = 0; j < 4; j++)
         cycle(1'b1, 1'b0, 4'h4, 4'h5, 4'h0, 4'h0, 1'b0, $sformatf("en_off_%0d", j));
      cycle(1'b1, 1'b1, 4'h4, 4'h4, 4'h0, 4'h1, 1'b1, "en_resume");
      cycle(1'b1, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 1'b0, "en_quiet");

      // Reset mid-operation with a pending ch0 count: back to 0 with no pulse,
      // then the full 5-edge latency applies again.
      for (int j = 0; j < 4; j++)
         cycle(1'b1, 1'b1, 4'h5, 4'h4, 4'h0, 4'h0, 1'b0, $sformatf("mid_run_%0d", j));
      cycle(1'b0, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, "mid_reset");
      for (int j = 0; j < 4; j++)
         cycle(1'b1, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, $sformatf("mid_rel_%0d", j));
      cycle(1'b1, 1'b1, 4'h5, 4'h5, 4'h5, 4'h0, 1'b1, "mid_update");
      cycle(1'b1, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0, "mid_quiet");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
